// File: rtl/instr_addr_sequencer_if.sv
// Fetch-address bus between the instruction address sequencer and the processor.
// master = sequencer side, slave = processor side.
interface instr_addr_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              instr_done;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              halt_req;
    logic [ADDR_W-1:0] cur_add;
    logic              addr_valid;
    logic              busy;
    logic              halted;
    logic [CNT_W-1:0]  retired_cnt;
    logic              timeout_err;

    modport master (
        input  start,
        input  instr_done,
        input  branch_taken,
        input  branch_target,
        input  halt_req,
        output cur_add,
        output addr_valid,
        output busy,
        output halted,
        output retired_cnt,
        output timeout_err
    );

    modport slave (
        output start,
        output instr_done,
        output branch_taken,
        output branch_target,
        output halt_req,
        input  cur_add,
        input  addr_valid,
        input  busy,
        input  halted,
        input  retired_cnt,
        input  timeout_err
    );
endinterface

// File: rtl/instr_addr_sequencer.sv
// Fetch-stage PC sequencer: issues one address per instruction, branches, halts.
// Optional WAIT-state watchdog is enabled by defining SEQ_WATCHDOG_EN.
module instr_addr_sequencer #(
    parameter int              ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = 8'h00,
    parameter logic [ADDR_W-1:0] END_ADDR   = 8'hFF,
    parameter int              CNT_W      = 16,
    parameter int              TIMEOUT    = 32
) (
    input logic clk,
    input logic rst,
    instr_addr_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HALT
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              retire_end;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            terr_q, terr_d;
    logic            wd_expire;

    assign wd_expire = (wd_q == WD_W'(TIMEOUT - 1));

    // Counts completed WAIT cycles; any other state re-arms it.
    always_comb begin
        wd_d = '0;
        if (state_q == WAIT) begin
            wd_d = wd_q + WD_W'(1);
        end
    end
`endif

    assign retire_end = (pc_q == END_ADDR);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
`ifdef SEQ_WATCHDOG_EN
        terr_d  = terr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.instr_done) begin
                    cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                    pc_d  = bus.branch_taken ? bus.branch_target
                                             : pc_q + ADDR_W'(1);
                    // Halt still takes the updated pc so HALT shows the next address.
                    if (bus.halt_req || retire_end) begin
                        state_d = HALT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wd_expire) begin
                    state_d = HALT;
                    terr_d  = 1'b1;
                end
`endif
            end
            HALT: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    pc_d    = START_ADDR;
                    cnt_d   = '0;
`ifdef SEQ_WATCHDOG_EN
                    terr_d  = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they align with state_q.
    always_comb begin
        valid_d  = (state_d == ISSUE);
        busy_d   = (state_d == ISSUE) || (state_d == WAIT);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= START_ADDR;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q   <= '0;
            terr_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            terr_q <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.cur_add     = pc_q;
    assign bus.addr_valid  = valid_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
    assign bus.retired_cnt = cnt_q;

endmodule
